load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the data-memory interface. Accepts load/store requests from the CPU datapath and sequences MemRead/MemWrite/address/writeData against the word-organised data memory. Supports byte, halfword and word accesses, including sign or zero extension on loads and read-modify-write for sub-word stores. Sits between the MEM-stage control and the data memory; the memory reads combinationally and writes on posedge clk.

Parameters:
ADDR_WIDTH, 32, width of req_addr and address.
CHECK_ALIGN, 1, 1 = misaligned half/word requests are flagged and skipped; 0 = low address bits below access size are forced to zero and the access proceeds.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores/misaligned)
resp_misaligned  output  1  valid with resp_valid
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
address  output  ADDR_WIDTH  word-aligned address {addr[hi:2],2'b00}
writeData  output  32  merged word to write
readData  input  32  combinational memory read data

Behaviour:
- Reset (sync, active-high): state IDLE; req_ready=1; resp_valid, resp_misaligned, MemRead, MemWrite = 0; resp_rdata, address, writeData, all latched request registers = 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: req_ready=1. Handshake = req_valid & req_ready at rising edge; latch write, size, unsigned, addr, wdata. Next state:
  - misaligned (CHECK_ALIGN=1; half with addr[0]=1, word with addr[1:0]!=0) -> DONE, misaligned flag set, no memory strobe.
  - load -> READ. Word store -> WRITE. Byte/half store -> READ (RMW).
- READ: MemRead=1 for exactly one cycle; readData registered at end of cycle. Load -> DONE; store -> WRITE.
- WRITE: MemWrite=1 for exactly one cycle; writeData = read word with selected lane replaced (byte lane k=addr[1:0], bits 8k+7:8k; half lane h=addr[1], bits 16h+15:16h); word store writes req_wdata directly. -> DONE.
- DONE: resp_valid=1 one cycle, req_ready=0, resp_misaligned per flag. -> IDLE.
- Little-endian lane mapping. Load extraction: byte/half from registered read word, extended per req_unsigned; word unmodified.
- Latency from accepting edge to resp_valid cycle: load 2, word store 2, sub-word store 3, misaligned 1. Throughput: next accept earliest in the IDLE cycle after DONE.
- MemRead/MemWrite never asserted together; writeData = 0 outside WRITE; address holds latched aligned address from accept until next accept.
- resp_rdata, resp_misaligned registered; hold value until the next DONE.
- req inputs ignored outside IDLE; changes mid-operation have no effect.
- Reset mid-operation: next cycle IDLE, no further strobes, no resp_valid. A WRITE cycle whose closing edge samples reset still commits to memory (memory samples MemWrite on that edge); this is required behaviour.

Test Plan:
- Store word 0x11223344 to 0x10, then load word 0x10 -> exactly one MemWrite cycle with address=0x10, writeData=0x11223344; load resp_rdata=0x11223344 two cycles after accept.
- After above, store byte 0xAB to 0x11 -> READ cycle then WRITE with writeData=0x1122AB44; resp_valid three cycles after accept.
- Loads from 0x10 word 0x1122AB44: lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB; lh 0x12 -> 0x00001122; sh 0x12 data 0xBEEF then lhu 0x12 -> 0x0000BEEF.
- Half store to 0x13 and word load from 0x12 (CHECK_ALIGN=1) -> resp_valid one cycle after accept, resp_misaligned=1, resp_rdata=0, MemRead/MemWrite never high; memory unchanged.
- Reset asserted during READ of byte store to 0x14 -> next cycle IDLE, req_ready=1, no MemWrite, no resp_valid, word 0x14 unchanged.
- req_valid held high with back-to-back word loads 0x10, 0x14 -> accepts spaced 3 cycles, two resp_valid pulses with correct data, req_ready low between.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator: sequences byte/half/word loads and stores against a
// word-organised memory, with sign/zero extension and read-modify-write.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_misaligned,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           writeData,
    input  logic [31:0]           readData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic                  req_write_q;
    logic [1:0]            req_size_q;
    logic                  req_unsigned_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [31:0]           req_wdata_q;
    logic [31:0]           read_word_q;

    logic                  accept;
    logic                  size_word;
    logic                  size_half;
    logic                  misaligned_req;
    logic [ADDR_WIDTH-1:0] addr_fixed;

    // Little-endian lane extraction with optional sign extension.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  lane
    );
        logic signed [7:0]  b_val;
        logic signed [15:0] h_val;
        logic [31:0]        result;
        b_val = word[{lane, 3'b000} +: 8];
        h_val = word[{lane[1], 4'b0000} +: 16];
        if (size[1]) begin
            result = word;
        end else if (size[0]) begin
            result = uns ? {16'h0000, h_val} : {{16{h_val[15]}}, h_val};
        end else begin
            result = uns ? {24'h000000, b_val} : {{24{b_val[7]}}, b_val};
        end
        return result;
    endfunction

    // Replace the addressed lane of the old word with the store data.
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] result;
        result = word;
        if (size[1]) begin
            result = wdata;
        end else if (size[0]) begin
            result[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            result[{lane, 3'b000} +: 8] = wdata[7:0];
        end
        return result;
    endfunction

    assign size_word = req_size[1];
    assign size_half = (req_size == 2'b01);
    assign accept    = req_valid & req_ready;

    assign misaligned_req = CHECK_ALIGN &&
                            ((size_half && req_addr[0]) ||
                             (size_word && (req_addr[1:0] != 2'b00)));

    // Without alignment checking the low bits are dropped so the access still lands in-lane.
    always_comb begin
        addr_fixed = req_addr;
        if (!CHECK_ALIGN) begin
            if (size_word) begin
                addr_fixed[1:0] = 2'b00;
            end else if (size_half) begin
                addr_fixed[0] = 1'b0;
            end
        end
    end

    assign address = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        resp_valid = 1'b0;
        writeData  = 32'h0000_0000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (misaligned_req) begin
                        state_next = DONE;
                    end else if (!req_write) begin
                        state_next = READ;
                    end else if (size_word) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                MemRead    = 1'b1;
                state_next = req_write_q ? WRITE : DONE;
            end
            WRITE: begin
                MemWrite   = 1'b1;
                writeData  = merge_store(read_word_q, req_wdata_q, req_size_q, req_addr_q[1:0]);
                state_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            req_write_q     <= 1'b0;
            req_size_q      <= 2'b00;
            req_unsigned_q  <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= 32'h0000_0000;
            read_word_q     <= 32'h0000_0000;
            resp_rdata      <= 32'h0000_0000;
            resp_misaligned <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_write_q    <= req_write;
                req_size_q     <= req_size;
                req_unsigned_q <= req_unsigned;
                req_addr_q     <= addr_fixed;
                req_wdata_q    <= req_wdata;
            end
            if (state == READ) begin
                read_word_q <= readData;
            end
            // Response registers only change when entering DONE, so they hold between responses.
            if (state_next == DONE) begin
                resp_misaligned <= (state == IDLE) && misaligned_req;
                resp_rdata      <= (state == READ && !req_write_q) ?
                                   extend_load(readData, req_size_q, req_unsigned_q, req_addr_q[1:0]) :
                                   32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a small word-organised memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int cycle     = 0;
    int rd_cnt    = 0;
    int wr_cnt    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    bit          mem_init_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    load_store_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .address(address),
        .writeData(writeData),
        .readData(readData)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | (i * 32'h0000_0101);
    endfunction

    // Memory reads combinationally and writes on the rising edge, regardless of reset.
    assign readData = mem[address[7:2]];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (MemWrite) begin
            mem[address[7:2]] <= writeData;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // Strobe and response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (MemRead && MemWrite) check_val("strobe_excl", 32'd1, 32'd0);
            if (MemRead) begin
                rd_cnt++;
                if (sb_q.size() > 0) check_val("rd_addr", address, sb_q[0].waddr);
            end
            if (MemWrite) begin
                wr_cnt++;
                if (sb_q.size() > 0) begin
                    check_val("wr_addr", address, sb_q[0].waddr);
                    check_val("wr_data", writeData, sb_q[0].wdata);
                end else begin
                    check_val("stray_write", 32'd1, 32'd0);
                end
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("stray_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("rdata", resp_rdata, e.rdata);
                    check_val("misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
                    check_val("latency", 32'(cycle - e.acc), 32'(e.lat));
                    check_val("read_strobes", 32'(rd_cnt), 32'(e.nrd));
                    check_val("write_strobes", 32'(wr_cnt), 32'(e.nwr));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Reference model: compute the expected response and update the shadow memory.
    task automatic push_expect(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd, input int acc);
        exp_t        e;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        int          sh;
        bit          isword;
        bit          ishalf;
        word   = ref_mem[a[7:2]];
        sh     = 8 * int'(a[1:0]);
        isword = sz[1];
        ishalf = (sz == 2'b01);
        e.acc   = acc;
        e.waddr = {a[31:2], 2'b00};
        e.rdata = 32'd0;
        e.wdata = 32'd0;
        e.mis   = (ishalf && a[0]) || (isword && (a[1:0] != 2'b00));
        if (e.mis) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!wr) begin
            e.lat = 2; e.nrd = 1; e.nwr = 0;
            v = word >> sh;
            if (isword) e.rdata = word;
            else if (ishalf) e.rdata = (uns || !v[15]) ? (v & 32'h0000FFFF) : (v | 32'hFFFF0000);
            else e.rdata = (uns || !v[7]) ? (v & 32'h000000FF) : (v | 32'hFFFFFF00);
        end else if (isword) begin
            e.lat = 2; e.nrd = 0; e.nwr = 1;
            e.wdata = wd;
            ref_mem[a[7:2]] = wd;
        end else begin
            e.lat = 3; e.nrd = 1; e.nwr = 1;
            mask    = (ishalf ? 32'h0000FFFF : 32'h000000FF) << sh;
            e.wdata = (word & ~mask) | ((wd << sh) & mask);
            ref_mem[a[7:2]] = e.wdata;
        end
        sb_q.push_back(e);
    endtask

    // Drives a request (called at posedge+2) and returns just after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit track, input bit hold, output int acc);
        bit rdy;
        bit done;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        done = 1'b0;
        acc  = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            rdy = req_ready;
            acc = cycle;
            @(posedge clk);
            #2;
            if (rdy) done = 1'b1;
        end
        if (!done) check_val("accept_timeout", 32'd0, 32'd1);
        else if (track) push_expect(wr, sz, uns, a, wd, acc);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb_q.size() > 0; n++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() > 0) begin
            check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        int acc;
        int acc2;
        logic [1:0]  sz;
        logic [31:0] a;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_misaligned", {31'd0, resp_misaligned}, 32'd0);
        check_val("rst_memread", {31'd0, MemRead}, 32'd0);
        check_val("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check_val("rst_rdata", resp_rdata, 32'd0);
        check_val("rst_address", address, 32'd0);
        check_val("rst_writedata", writeData, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h00005555, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, acc);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, acc);
        drain();

        // Reset during the READ phase of a byte store must abandon it.
        issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000077, 1'b0, 1'b0, acc);
        reset = 1'b1;
        @(negedge clk);
        check_val("rmw_read_strobe", {31'd0, MemRead}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("post_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check_val("post_rst_resp", {31'd0, resp_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #2;
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, acc);
        drain();

        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, acc2);
        check_val("b2b_spacing", 32'(acc2 - acc), 32'd3);
        drain();

        for (int i = 0; i < 12; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(32, 63));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, 1'b0, acc);
        end
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
